// File: rtl/airi5c_fpu_sequencer.sv
// Sequences single-precision F-extension operations onto the one-hot FPU core:
// decodes op and rounding mode, issues a load pulse, waits for ready under a watchdog.
module airi5c_fpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  frm,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic        resp_illegal,
  output logic        resp_timeout,
  output logic        core_load,
  output logic        core_kill,
  output logic [17:0] core_op,
  output logic [2:0]  core_rm,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_result,
  input  logic        core_IV,
  input  logic        core_DZ,
  input  logic        core_OF,
  input  logic        core_UF,
  input  logic        core_IE,
  input  logic        core_ready
);

  localparam int unsigned OP_W  = 18;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  localparam int unsigned OP_ADD = 17, OP_SUB = 16, OP_MUL = 15, OP_DIV = 14;
  localparam int unsigned OP_SQRT = 13, OP_SGNJ = 12, OP_SGNJN = 11, OP_SGNJX = 10;
  localparam int unsigned OP_CVTFI = 9, OP_CVTFU = 8, OP_CVTIF = 7, OP_CVTUF = 6;
  localparam int unsigned OP_EQ = 5, OP_LT = 4, OP_LE = 3, OP_CLASS = 2;
  localparam int unsigned OP_MIN = 1, OP_MAX = 0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t            state, state_next;
  logic [OP_W-1:0]   dec_op;
  logic [2:0]        dec_rm, rm_sel;
  logic              uses_rm, dec_legal;
  logic              accept, abort;
  logic [CNT_W-1:0]  wd_cnt;

  // Instruction decode into one-hot core opcode plus resolved rounding mode
  always_comb begin
    dec_op  = '0;
    uses_rm = 1'b0;
    case (req_funct7)
      7'b0000000: begin dec_op[OP_ADD] = 1'b1; uses_rm = 1'b1; end
      7'b0000100: begin dec_op[OP_SUB] = 1'b1; uses_rm = 1'b1; end
      7'b0001000: begin dec_op[OP_MUL] = 1'b1; uses_rm = 1'b1; end
      7'b0001100: begin dec_op[OP_DIV] = 1'b1; uses_rm = 1'b1; end
      7'b0101100: if (req_rs2 == 5'd0) begin dec_op[OP_SQRT] = 1'b1; uses_rm = 1'b1; end
      7'b0010000:
        case (req_funct3)
          3'b000:  dec_op[OP_SGNJ]  = 1'b1;
          3'b001:  dec_op[OP_SGNJN] = 1'b1;
          3'b010:  dec_op[OP_SGNJX] = 1'b1;
          default: ;
        endcase
      7'b0010100:
        case (req_funct3)
          3'b000:  dec_op[OP_MIN] = 1'b1;
          3'b001:  dec_op[OP_MAX] = 1'b1;
          default: ;
        endcase
      7'b1010000:
        case (req_funct3)
          3'b000:  dec_op[OP_LE] = 1'b1;
          3'b001:  dec_op[OP_LT] = 1'b1;
          3'b010:  dec_op[OP_EQ] = 1'b1;
          default: ;
        endcase
      7'b1100000:
        case (req_rs2)
          5'd0:    begin dec_op[OP_CVTFI] = 1'b1; uses_rm = 1'b1; end
          5'd1:    begin dec_op[OP_CVTFU] = 1'b1; uses_rm = 1'b1; end
          default: ;
        endcase
      7'b1101000:
        case (req_rs2)
          5'd0:    begin dec_op[OP_CVTIF] = 1'b1; uses_rm = 1'b1; end
          5'd1:    begin dec_op[OP_CVTUF] = 1'b1; uses_rm = 1'b1; end
          default: ;
        endcase
      7'b1110000: if (req_funct3 == 3'b001) dec_op[OP_CLASS] = 1'b1;
      default: ;
    endcase
    rm_sel    = (req_funct3 == 3'b111) ? frm : req_funct3;
    dec_rm    = uses_rm ? rm_sel : 3'b000;
    dec_legal = (dec_op != '0) && !(uses_rm && (rm_sel > 3'b100));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next state; kill overrides everything and also reaches the core directly
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    abort      = 1'b0;
    req_ready  = (state == S_IDLE) && !kill;
    case (state)
      S_IDLE: if (req_valid && req_ready) begin
        accept     = 1'b1;
        state_next = dec_legal ? S_LOAD : S_DONE;
      end
      S_LOAD: state_next = S_WAIT;
      S_WAIT:
        if (core_ready) begin
          state_next = S_DONE;
        end else if (wd_cnt == TIMEOUT_CNT) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      S_DONE: if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
    core_kill = kill | abort;
  end

  // Registered datapath: operands/op at accept, result/flags at completion
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      core_load    <= 1'b0;
      resp_valid   <= 1'b0;
      core_a       <= '0;
      core_b       <= '0;
      core_op      <= '0;
      core_rm      <= '0;
      resp_result  <= '0;
      resp_flags   <= '0;
      resp_illegal <= 1'b0;
      resp_timeout <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      core_load  <= (state_next == S_LOAD);
      resp_valid <= (state_next == S_DONE);
      if (accept) begin
        core_a       <= req_a;
        core_b       <= req_b;
        core_op      <= dec_op;
        core_rm      <= dec_rm;
        resp_illegal <= !dec_legal;
        resp_timeout <= 1'b0;
        resp_result  <= '0;
        resp_flags   <= '0;
      end
      if (state == S_LOAD)
        wd_cnt <= '0;
      else if (state == S_WAIT && wd_cnt != '1)
        wd_cnt <= wd_cnt + CNT_W'(1);
      if (state == S_WAIT && !kill) begin
        if (core_ready) begin
          resp_result <= core_result;
          resp_flags  <= {core_IV, core_DZ, core_OF, core_UF, core_IE};
        end else if (abort) begin
          resp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_airi5c_fpu_sequencer.sv
// Scenario bench for airi5c_fpu_sequencer with a programmable core stub and a
// response scoreboard fed by each test as it drives a request.
module tb_airi5c_fpu_sequencer;

  logic        clk = 1'b0, n_reset = 1'b0, kill = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [6:0]  req_funct7 = '0;
  logic [2:0]  req_funct3 = '0, frm = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic        resp_illegal, resp_timeout;
  logic        core_load, core_kill, core_ready;
  logic [17:0] core_op;
  logic [2:0]  core_rm;
  logic [31:0] core_a, core_b, core_result;
  logic        core_IV, core_DZ, core_OF, core_UF, core_IE;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        ill;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  airi5c_fpu_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_reset(n_reset), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct7(req_funct7), .req_funct3(req_funct3), .req_rs2(req_rs2),
    .req_a(req_a), .req_b(req_b), .frm(frm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .resp_illegal(resp_illegal), .resp_timeout(resp_timeout),
    .core_load(core_load), .core_kill(core_kill), .core_op(core_op), .core_rm(core_rm),
    .core_a(core_a), .core_b(core_b), .core_result(core_result),
    .core_IV(core_IV), .core_DZ(core_DZ), .core_OF(core_OF), .core_UF(core_UF),
    .core_IE(core_IE), .core_ready(core_ready)
  );

  // Core stub: answers stub_lat cycles into WAIT unless told never to
  logic [31:0] stub_result = '0;
  logic [4:0]  stub_flags  = '0;
  int          stub_lat    = 0;
  logic        stub_never  = 1'b0;
  logic        stub_busy;
  int          stub_cnt;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (core_kill) begin
      stub_busy <= 1'b0;
    end else if (core_load) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat;
    end else if (stub_busy) begin
      if (core_ready) stub_busy <= 1'b0;
      else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end
  end
  assign core_ready  = stub_busy && (stub_cnt == 0) && !stub_never;
  assign core_result = stub_result;
  assign {core_IV, core_DZ, core_OF, core_UF, core_IE} = stub_flags;

  // Scoreboard consumer: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (n_reset && resp_valid && resp_ready) begin
      exp_t got, e;
      got = {resp_result, resp_flags, resp_illegal, resp_timeout};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected got=%h/%b/%b/%b", resp_result, resp_flags, resp_illegal, resp_timeout);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL resp got=%h/%b/ill%b/to%b exp=%h/%b/ill%b/to%b",
                   got.res, got.fl, got.ill, got.to, e.res, e.fl, e.ill, e.to);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic [4:0] f, input logic ill, input logic to);
    exp_t e;
    e.res = r; e.fl = f; e.ill = ill; e.to = to;
    exp_q.push_back(e);
  endtask

  // Drives one request until accepted; returns just after the accept edge (LOAD cycle)
  task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs2,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    req_funct7 = f7; req_funct3 = f3; req_rs2 = rs2; req_a = a; req_b = b;
    req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; $display("FAIL accept_timeout req_ready=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    #12;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); else passed++;
    total++; if (core_load !== 1'b0 || core_kill !== 1'b0) $display("FAIL rst_load_kill got=%b%b exp=00", core_load, core_kill); else passed++;
    total++; if (core_op !== 18'h0 || core_rm !== 3'h0) $display("FAIL rst_op_rm got=%h/%h exp=0/0", core_op, core_rm); else passed++;
    total++; if (core_a !== 32'h0 || resp_result !== 32'h0) $display("FAIL rst_data got=%h/%h exp=0/0", core_a, resp_result); else passed++;
    @(negedge clk); n_reset = 1'b1;
    step();
  endtask

  task automatic test_fadd();
    stub_result = 32'h40400000; stub_flags = 5'b00000; stub_lat = 0;
    push_exp(32'h40400000, 5'b00000, 1'b0, 1'b0);
    send(7'b0000000, 3'b000, 5'd0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    total++; if (core_load !== 1'b1) $display("FAIL fadd_load got=%b exp=1", core_load); else passed++;
    total++; if (core_op !== 18'h20000 || core_rm !== 3'b000) $display("FAIL fadd_op_rm got=%h/%b exp=20000/000", core_op, core_rm); else passed++;
    total++; if (core_a !== 32'h3F800000 || core_b !== 32'h40000000) $display("FAIL fadd_operands got=%h/%h exp=3f800000/40000000", core_a, core_b); else passed++;
    @(negedge clk);
    total++; if (core_load !== 1'b0 || resp_valid !== 1'b0) $display("FAIL fadd_wait got load=%b valid=%b exp=0/0", core_load, resp_valid); else passed++;
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) $display("FAIL fadd_min_latency got=%b exp=1", resp_valid); else passed++;
    drain();
  endtask

  task automatic test_fdiv_zero();
    stub_result = 32'h7F800000; stub_flags = 5'b01000; stub_lat = 3;
    push_exp(32'h7F800000, 5'b01000, 1'b0, 1'b0);
    send(7'b0001100, 3'b000, 5'd0, 32'h3F800000, 32'h00000000);
    @(negedge clk);
    total++; if (core_op !== 18'h04000) $display("FAIL fdiv_op got=%h exp=04000", core_op); else passed++;
    drain();
    stub_flags = 5'b00000;
  endtask

  task automatic test_rounding();
    frm = 3'b001; stub_result = 32'h40400000; stub_lat = 1;
    push_exp(32'h40400000, 5'b00000, 1'b0, 1'b0);
    send(7'b0000000, 3'b111, 5'd0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    total++; if (core_rm !== 3'b001) $display("FAIL dyn_rm got=%b exp=001", core_rm); else passed++;
    drain();
    frm = 3'b101;
    push_exp(32'h0, 5'b00000, 1'b1, 1'b0);
    send(7'b0000000, 3'b111, 5'd0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    total++; if (core_load !== 1'b0 || resp_valid !== 1'b1) $display("FAIL bad_frm got load=%b valid=%b exp=0/1", core_load, resp_valid); else passed++;
    drain();
    frm = 3'b000;
    push_exp(32'h0, 5'b00000, 1'b1, 1'b0);
    send(7'b1110000, 3'b000, 5'd0, 32'h1, 32'h2);
    @(negedge clk);
    total++; if (core_load !== 1'b0) $display("FAIL illegal_class_load got=%b exp=0", core_load); else passed++;
    drain();
    stub_result = 32'h00000001; stub_lat = 0;
    push_exp(32'h00000001, 5'b00000, 1'b0, 1'b0);
    send(7'b1010000, 3'b010, 5'd0, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    total++; if (core_op !== 18'h00020 || core_rm !== 3'b000) $display("FAIL feq_op_rm got=%h/%b exp=00020/000", core_op, core_rm); else passed++;
    drain();
  endtask

  task automatic test_kill();
    stub_never = 1'b1;
    send(7'b0000000, 3'b000, 5'd0, 32'h3F800000, 32'h40000000);
    step();
    step();
    kill = 1'b1; req_valid = 1'b1; req_funct7 = 7'b0000000; req_funct3 = 3'b000;
    @(negedge clk);
    total++; if (core_kill !== 1'b1 || req_ready !== 1'b0) $display("FAIL kill_cycle got kill=%b rdy=%b exp=1/0", core_kill, req_ready); else passed++;
    step();
    kill = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++; if (core_load !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL kill_after got load=%b rdy=%b valid=%b exp=0/1/0", core_load, req_ready, resp_valid); else passed++;
    repeat (3) @(negedge clk);
    total++; if (resp_valid !== 1'b0) $display("FAIL kill_no_resp got=%b exp=0", resp_valid); else passed++;
    stub_never = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    int  n;
    bit  got;
    stub_never = 1'b1; stub_result = 32'hDEADBEEF; stub_flags = 5'b11111;
    push_exp(32'h0, 5'b00000, 1'b0, 1'b1);
    send(7'b0001000, 3'b000, 5'd0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    n = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_kill) begin got = 1'b1; break; end
      n++;
    end
    total++; if (!got || n != 16) $display("FAIL wd_cycles got=%0d seen=%b exp=16", n, got); else passed++;
    @(negedge clk);
    total++; if (core_kill !== 1'b0 || resp_timeout !== 1'b1) $display("FAIL wd_pulse got kill=%b to=%b exp=0/1", core_kill, resp_timeout); else passed++;
    drain();
    stub_never = 1'b0; stub_flags = 5'b00000;
  endtask

  task automatic test_back_to_back();
    bit ok;
    resp_ready = 1'b0;
    stub_result = 32'hBF800000; stub_lat = 2;
    push_exp(32'hBF800000, 5'b00000, 1'b0, 1'b0);
    send(7'b0010100, 3'b000, 5'd0, 32'hBF800000, 32'h3F800000);
    @(negedge clk);
    total++; if (core_op !== 18'h00002) $display("FAIL fmin_op got=%h exp=00002", core_op); else passed++;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin total++; $display("FAIL bp_resp_timeout got=%b exp=1", resp_valid); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_result !== 32'hBF800000 || resp_flags !== 5'b0 || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b r=%h f=%b rdy=%b exp=1/bf800000/0/0", k, resp_valid, resp_result, resp_flags, req_ready);
      else passed++;
    end
    step();
    resp_ready = 1'b1;
    stub_result = 32'h3F800000; stub_lat = 0;
    push_exp(32'h3F800000, 5'b00000, 1'b0, 1'b0);
    req_funct7 = 7'b0010000; req_funct3 = 3'b010; req_rs2 = 5'd0;
    req_a = 32'h3F800000; req_b = 32'h40000000; req_valid = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_resp_cycle got=%b exp=0", req_ready); else passed++;
    step();
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", req_ready); else passed++;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (core_load !== 1'b1 || core_op !== 18'h00400) $display("FAIL b2b_load got=%b/%h exp=1/00400", core_load, core_op); else passed++;
    drain();
  endtask

  task automatic test_reset_midop();
    stub_never = 1'b1;
    send(7'b0000000, 3'b000, 5'd0, 32'h12345678, 32'h9ABCDEF0);
    step();
    #2 n_reset = 1'b0;
    #1;
    total++; if (core_op !== 18'h0 || core_a !== 32'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL midop_reset got op=%h a=%h v=%b rdy=%b exp=0/0/0/1", core_op, core_a, resp_valid, req_ready); else passed++;
    @(negedge clk); n_reset = 1'b1;
    stub_never = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fadd();
    test_fdiv_zero();
    test_rounding();
    test_kill();
    test_watchdog();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
